// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, funct3 codes and access-size decode for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bytes touched by an access; illegal codes fault anyway, so their size is don't-care.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_size = 3'd1;
            F3_H, F3_HU: access_size = 3'd2;
            default:     access_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - combinational load lane extract/extend and store lane merge
module lsu_byte_lane (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    import lsu_pkg::*;

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[{offset, 3'b000} +: 8];
        lane_half = word[{offset[1], 4'b0000} +: 16];

        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'd0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'd0, lane_half};
            F3_W:    load_data = word;
            default: load_data = 32'd0;
        endcase

        merged = word;
        case (funct3)
            F3_B:    merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store initiator with RMW sub-word stores; LSU_RANGE_CHECK_EN enables the address range fault
module load_store_unit #(
    parameter int MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic [31:0] M_a,
    output logic [31:0] Mem_WriteData,
    input  logic [31:0] Mem_ReadData
);
    import lsu_pkg::*;

    lsu_state_t  state, state_next;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        illegal_f3;
    logic        misaligned;
    logic        range_fault;
    logic        fault;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept = req_valid && req_ready;

    always_comb begin
        illegal_f3 = 1'b0;
        if (req_we) begin
            illegal_f3 = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
        end else begin
            illegal_f3 = !(req_funct3 == F3_B  || req_funct3 == F3_H || req_funct3 == F3_W ||
                           req_funct3 == F3_BU || req_funct3 == F3_HU);
        end
        misaligned = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                     (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
    end

`ifdef LSU_RANGE_CHECK_EN
    // 33-bit end address so requests near the top of the space cannot wrap below the limit.
    logic [32:0] end_addr;
    assign end_addr    = {1'b0, req_addr} + {30'd0, access_size(req_funct3)};
    assign range_fault = end_addr > 33'(MEM_BYTES);
`else
    assign range_fault = 1'b0;
`endif

    assign fault = illegal_f3 || misaligned || range_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (fault) begin
                        state_next = RESP;
                    end else if (!req_we || req_funct3 != F3_W) begin
                        state_next = RD;
                    end else begin
                        state_next = WR;
                    end
                end
            end
            RD:      state_next = we_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    lsu_byte_lane u_lane (
        .word      (Mem_ReadData),
        .offset    (offset_q),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Strobes follow the next state so they are flops, never decoded from state.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q          <= 1'b0;
            funct3_q      <= 3'd0;
            offset_q      <= 2'd0;
            wdata_q       <= 32'd0;
            Mem_Read      <= 1'b0;
            Mem_Write     <= 1'b0;
            M_a           <= 32'd0;
            Mem_WriteData <= 32'd0;
            rsp_rdata     <= 32'd0;
            rsp_fault     <= 1'b0;
        end else begin
            Mem_Read  <= (state_next == RD);
            Mem_Write <= (state_next == WR);
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                offset_q <= req_addr[1:0];
                wdata_q  <= req_wdata;
                if (fault) begin
                    rsp_rdata <= 32'd0;
                    rsp_fault <= 1'b1;
                end else begin
                    M_a <= {req_addr[31:2], 2'b00};
                    if (state_next == WR) begin
                        Mem_WriteData <= req_wdata;
                    end
                end
            end
            if (state == RD) begin
                if (we_q) begin
                    Mem_WriteData <= merged;
                end else begin
                    rsp_rdata <= load_data;
                    rsp_fault <= 1'b0;
                end
            end
            if (state == WR) begin
                rsp_rdata <= 32'd0;
                rsp_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a word memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [31:0] M_a;
    logic [31:0] Mem_WriteData;
    logic [31:0] Mem_ReadData;

    logic [31:0] mem [0:7];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_fault     (rsp_fault),
        .Mem_Read      (Mem_Read),
        .Mem_Write     (Mem_Write),
        .M_a           (M_a),
        .Mem_WriteData (Mem_WriteData),
        .Mem_ReadData  (Mem_ReadData)
    );

    assign Mem_ReadData = (M_a < 32'd32) ? mem[M_a[4:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (Mem_Write && M_a < 32'd32) begin
            mem[M_a[4:2]] <= Mem_WriteData;
        end
    end

    // Issues one request and watches up to six cycles after the accept edge.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                           output logic flt, output int rd_cnt, output int wr_cnt,
                           output logic [31:0] wd_seen, output logic [31:0] ma_seen);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        lat = -1; rdata = 32'hX; flt = 1'bx;
        rd_cnt = 0; wr_cnt = 0; wd_seen = 32'd0; ma_seen = 32'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (Mem_Read) begin rd_cnt++; ma_seen = M_a; end
            if (Mem_Write) begin wr_cnt++; wd_seen = Mem_WriteData; ma_seen = M_a; end
            if (rsp_valid) begin
                lat = c; rdata = rsp_rdata; flt = rsp_fault;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if ({Mem_Read, Mem_Write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {Mem_Read, Mem_Write}); end
        checks++; if (M_a !== 32'd0 || Mem_WriteData !== 32'd0) begin errors++; $display("FAIL reset_mem_port got %h/%h want 0/0", M_a, Mem_WriteData); end
        checks++; if (rsp_rdata !== 32'd0 || rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_rdata, rsp_fault); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        int lat, rdc, wrc; logic [31:0] rd, wd, ma; logic f;
        run_req(1'b0, 3'b010, 32'h14, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'h5 || f !== 1'b0) begin errors++; $display("FAIL lw_data got %h/%b want 00000005/0", rd, f); end
        checks++; if (rdc !== 1 || wrc !== 0 || ma !== 32'h14) begin errors++; $display("FAIL lw_strobes got rd=%0d wr=%0d ma=%h want 1/0/14", rdc, wrc, ma); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_rdata !== 32'h5 || M_a !== 32'h14) begin errors++; $display("FAIL lw_hold got %h/%h want 00000005/00000014", rsp_rdata, M_a); end
    endtask

    task automatic test_sub_word();
        int lat, rdc, wrc; logic [31:0] rd, wd, ma; logic f;
        run_req(1'b1, 3'b000, 32'h15, 32'h123456AB, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d want 3", lat); end
        checks++; if (rdc !== 1 || wrc !== 1 || wd !== 32'h0000AB05) begin errors++; $display("FAIL sb_rmw got rd=%0d wr=%0d wdata=%h want 1/1/0000AB05", rdc, wrc, wd); end
        checks++; if (rd !== 32'd0 || f !== 1'b0) begin errors++; $display("FAIL sb_rsp got %h/%b want 0/0", rd, f); end
        run_req(1'b0, 3'b000, 32'h15, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (rd !== 32'hFFFFFFAB || lat !== 2) begin errors++; $display("FAIL lb_sign got %h lat %0d want FFFFFFAB lat 2", rd, lat); end
        run_req(1'b0, 3'b100, 32'h15, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (rd !== 32'h000000AB) begin errors++; $display("FAIL lbu_zero got %h want 000000AB", rd); end
        run_req(1'b1, 3'b001, 32'h16, 32'h0000BEEF, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (wd !== 32'hBEEFAB05 || lat !== 3) begin errors++; $display("FAIL sh_merge got %h lat %0d want BEEFAB05 lat 3", wd, lat); end
        run_req(1'b0, 3'b001, 32'h16, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_sign got %h want FFFFBEEF", rd); end
        run_req(1'b0, 3'b101, 32'h16, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_zero got %h want 0000BEEF", rd); end
        run_req(1'b0, 3'b000, 32'h14, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (rd !== 32'h00000005) begin errors++; $display("FAIL lb_lane0 got %h want 00000005", rd); end
        run_req(1'b1, 3'b010, 32'h18, 32'hCAFEF00D, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (lat !== 2 || rdc !== 0 || wd !== 32'hCAFEF00D || mem[6] !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_direct got lat %0d rd=%0d wdata=%h mem=%h want 2/0/CAFEF00D/CAFEF00D", lat, rdc, wd, mem[6]); end
    endtask

    task automatic test_faults();
        int lat, rdc, wrc; logic [31:0] rd, wd, ma; logic f;
        logic        we_v [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_v [4]  = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ad_v [4]  = '{32'h13, 32'h16, 32'h14, 32'h14};
        for (int i = 0; i < 4; i++) begin
            run_req(we_v[i], f3_v[i], ad_v[i], 32'hFFFFFFFF, lat, rd, f, rdc, wrc, wd, ma);
            checks++;
            if (lat !== 1 || f !== 1'b1 || rd !== 32'd0 || rdc !== 0 || wrc !== 0) begin
                errors++;
                $display("FAIL fault_%0d got lat %0d fault %b rdata %h rd=%0d wr=%0d want 1/1/0/0/0", i, lat, f, rd, rdc, wrc);
            end
        end
    endtask

    task automatic test_range();
        int lat, rdc, wrc; logic [31:0] rd, wd, ma; logic f;
        run_req(1'b0, 3'b010, 32'h1C, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (lat !== 2 || f !== 1'b0 || rd !== 32'h77665544) begin errors++; $display("FAIL range_last_word got lat %0d fault %b rdata %h want 2/0/77665544", lat, f, rd); end
        run_req(1'b0, 3'b010, 32'h20, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
`ifdef LSU_RANGE_CHECK_EN
        checks++; if (lat !== 1 || f !== 1'b1 || rdc !== 0) begin errors++; $display("FAIL range_over got lat %0d fault %b rd=%0d want 1/1/0", lat, f, rdc); end
        run_req(1'b0, 3'b000, 32'hFFFFFFFF, 32'd0, lat, rd, f, rdc, wrc, wd, ma);
        checks++; if (lat !== 1 || f !== 1'b1 || rdc !== 0) begin errors++; $display("FAIL range_wrap got lat %0d fault %b rd=%0d want 1/1/0", lat, f, rdc); end
`else
        checks++; if (lat !== 2 || f !== 1'b0 || rdc !== 1 || ma !== 32'h20 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL range_off got lat %0d fault %b rd=%0d ma=%h rdata=%h want 2/0/1/20/DEADBEEF", lat, f, rdc, ma, rd); end
`endif
    endtask

    task automatic test_reset_during_wr();
        int pulses = 0;
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h10; req_wdata = 32'h00007777;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (Mem_Write !== 1'b1) begin errors++; $display("FAIL sh_reach_wr got Mem_Write %b want 1", Mem_Write); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (Mem_Write !== 1'b0 || Mem_Read !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_in_wr got wr=%b rd=%b ready=%b want 0/0/1", Mem_Write, Mem_Read, req_ready); end
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid) pulses++;
            @(posedge clk); #1;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_rsp got %0d pulses want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [8:1] ready_seen, rsp_seen;
        int pulses = 0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 32'd0;
        req_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            ready_seen[c] = req_ready;
            rsp_seen[c]   = rsp_valid;
            if (rsp_valid) pulses++;
            if (c == 4) req_valid = 1'b0;
        end
        checks++; if (ready_seen !== 8'b1110_0100) begin errors++; $display("FAIL b2b_ready got %b want 11100100", ready_seen); end
        checks++; if (rsp_seen !== 8'b0001_0010 || pulses !== 2) begin errors++; $display("FAIL b2b_rsp got %b (%0d pulses) want 00010010 (2)", rsp_seen, pulses); end
        checks++; if (rsp_rdata !== 32'hBEEFAB05) begin errors++; $display("FAIL b2b_data got %h want BEEFAB05", rsp_rdata); end
    endtask

    initial begin
        mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h0;
        mem[4] = 32'h44332211; mem[5] = 32'h00000005;
        mem[6] = 32'h0; mem[7] = 32'h77665544;
        test_reset();
        test_load_word();
        test_sub_word();
        test_faults();
        test_range();
        test_reset_during_wr();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
